// File: rtl/clock_display.sv
// clock_display
//   Drives an 8-digit, common-anode, multiplexed 7-segment display as
//   HH-MM-SS from the binary time produced by the hh:mm:ss counter.
//   The time inputs are snapshotted once per scan frame, so every frame
//   shows one consistent time. All outputs are registered.
//
// Parameters
//   DIGIT_PERIOD_CYCLES : clock cycles each digit stays enabled (>= 2)
//
// Ports
//   clk_100MHz_i : system clock, rising edge
//   reset_i      : synchronous reset, active-high
//   seconds_i    : binary seconds, legal 0-59
//   minutes_i    : binary minutes, legal 0-59
//   hours_i      : binary hours, legal 0-23
//   an_o         : digit enables, active-low one-hot, an_o[0] = rightmost digit
//   seg_o        : segments, active-low, bit 0..6 = a..g, bit 7 = dp
//
// Optional build macro
//   SEP_BLINK_EN : when defined, the two separator digits blank while the
//                  snapshotted seconds value is odd (1 Hz blink). When the
//                  seconds field is out of range they stay as '-'.
module clock_display #(
  parameter int DIGIT_PERIOD_CYCLES = 100000
) (
  input  logic       clk_100MHz_i,
  input  logic       reset_i,
  input  logic [5:0] seconds_i,
  input  logic [5:0] minutes_i,
  input  logic [4:0] hours_i,
  output logic [7:0] an_o,
  output logic [7:0] seg_o
);

  localparam int CNT_W = (DIGIT_PERIOD_CYCLES > 2) ? $clog2(DIGIT_PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD_CYCLES - 1);

  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Decimal digit to active-low segment pattern, dp off.
  function automatic logic [7:0] seg_of(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Binary 0-63 to {tens, ones}. Six conditional subtractions of ten are
  // enough for the largest 6-bit value (63 -> 6 tens, 3 ones).
  function automatic logic [7:0] bcd_of(input logic [5:0] value);
    logic [5:0] rem;
    logic [3:0] tens;
    rem  = value;
    tens = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]       digit_idx_q, digit_idx_d;
  logic [5:0]       snap_s_q, snap_s_d;
  logic [5:0]       snap_m_q, snap_m_d;
  logic [4:0]       snap_h_q, snap_h_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic [7:0] bcd_s, bcd_m, bcd_h;
  logic       s_oor, m_oor, h_oor;
  logic [7:0] sep_code;
  logic       frame_end;

  // Scan timing and frame-synchronous snapshot.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    snap_s_d    = snap_s_q;
    snap_m_d    = snap_m_q;
    snap_h_d    = snap_h_q;
    frame_end   = 1'b0;
    if (scan_cnt_q == CNT_LAST) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 1'b1;
      // Capture on the last cycle of digit 7 so the next frame starts
      // with the fresh value and never changes mid-frame.
      if (digit_idx_q == 3'd7) begin
        frame_end = 1'b1;
        snap_s_d  = seconds_i;
        snap_m_d  = minutes_i;
        snap_h_d  = hours_i;
      end
    end
  end

  // Segment selection for the digit currently addressed by digit_idx_q.
  always_comb begin
    bcd_s = bcd_of(snap_s_q);
    bcd_m = bcd_of(snap_m_q);
    bcd_h = bcd_of({1'b0, snap_h_q});
    s_oor = (snap_s_q > 6'd59);
    m_oor = (snap_m_q > 6'd59);
    h_oor = (snap_h_q > 5'd23);

    sep_code = SEG_DASH;
`ifdef SEP_BLINK_EN
    if (!s_oor && snap_s_q[0]) begin
      sep_code = SEG_BLANK;
    end
`else
    sep_code = SEG_DASH;
`endif

    an_d = ~(8'b1 << digit_idx_q);
    case (digit_idx_q)
      3'd0:    seg_d = s_oor ? SEG_E : seg_of(bcd_s[3:0]);
      3'd1:    seg_d = s_oor ? SEG_E : seg_of(bcd_s[7:4]);
      3'd2:    seg_d = sep_code;
      3'd3:    seg_d = m_oor ? SEG_E : seg_of(bcd_m[3:0]);
      3'd4:    seg_d = m_oor ? SEG_E : seg_of(bcd_m[7:4]);
      3'd5:    seg_d = sep_code;
      3'd6:    seg_d = h_oor ? SEG_E : seg_of(bcd_h[3:0]);
      default: seg_d = h_oor ? SEG_E : seg_of(bcd_h[7:4]);
    endcase
  end

  always_ff @(posedge clk_100MHz_i) begin
    if (reset_i) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= 3'd0;
      snap_s_q    <= 6'd0;
      snap_m_q    <= 6'd0;
      snap_h_q    <= 5'd0;
      an_q        <= 8'hFF;
      seg_q       <= 8'hFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      snap_s_q    <= snap_s_d;
      snap_m_q    <= snap_m_d;
      snap_h_q    <= snap_h_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

  // frame_end is kept for readability of the capture condition only.
  logic unused_frame_end;
  assign unused_frame_end = frame_end;

endmodule

// File: tb/tb_clock_display.sv
module tb_clock_display;

  localparam int DP    = 4;
  localparam int FRAME = 8 * DP;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [5:0] seconds_i;
  logic [5:0] minutes_i;
  logic [4:0] hours_i;
  logic [7:0] an_o;
  logic [7:0] seg_o;

  always #5 clk = ~clk;

  clock_display #(.DIGIT_PERIOD_CYCLES(DP)) dut (
    .clk_100MHz_i(clk),
    .reset_i     (reset_i),
    .seconds_i   (seconds_i),
    .minutes_i   (minutes_i),
    .hours_i     (hours_i),
    .an_o        (an_o),
    .seg_o       (seg_o)
  );

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;  // edges since last reset release
  int disp_s = 0, disp_m = 0, disp_h = 0;
  int pend_s = 0, pend_m = 0, pend_h = 0;
  logic [7:0] seg_tab[10];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d after release)", tag, got, exp, k);
    end
  endtask

  function automatic logic [7:0] field_seg(input int v, input bit tens, input bit oor);
    if (oor) return 8'h86;
    return tens ? seg_tab[v / 10] : seg_tab[v % 10];
  endfunction

  function automatic exp_t model(input int d, input int s, input int m, input int h);
    exp_t r;
    logic [7:0] one;
    logic [7:0] sep;
    one  = 8'b1;
    r.an = ~(one << d);
`ifdef SEP_BLINK_EN
    sep = (s <= 59 && (s % 2) == 1) ? 8'hFF : 8'hBF;
`else
    sep = 8'hBF;
`endif
    case (d)
      0:       r.seg = field_seg(s, 1'b0, s > 59);
      1:       r.seg = field_seg(s, 1'b1, s > 59);
      2:       r.seg = sep;
      3:       r.seg = field_seg(m, 1'b0, m > 59);
      4:       r.seg = field_seg(m, 1'b1, m > 59);
      5:       r.seg = sep;
      6:       r.seg = field_seg(h, 1'b0, h > 23);
      default: r.seg = field_seg(h, 1'b1, h > 23);
    endcase
    return r;
  endfunction

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: queue empty, got an=%h seg=%h expected an entry", an_o, seg_o);
    end else begin
      e = sb.pop_front();
      check("an_o", an_o, e.an);
      check("seg_o", seg_o, e.seg);
    end
  endtask

  // One clock with reset low. Inputs are already stable for the coming edge.
  task automatic tick();
    int e;
    e = k + 1;
    // A new frame begins at this edge; it shows what was captured one edge earlier.
    if (e > 1 && ((e - 1) % FRAME) == 0) begin
      disp_s = pend_s;
      disp_m = pend_m;
      disp_h = pend_h;
    end
    sb.push_back(model(((e - 1) / DP) % 8, disp_s, disp_m, disp_h));
    if ((e % FRAME) == 0) begin
      pend_s = int'(seconds_i);
      pend_m = int'(minutes_i);
      pend_h = int'(hours_i);
    end
    @(posedge clk);
    k = e;
    @(negedge clk);
    pop_check();
    if ((e % FRAME) == 0)
      $display("frame ending at edge %0d: expected display %0d-%0d-%0d, checks=%0d", e, disp_h, disp_m, disp_s, n_checks);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    reset_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{an: 8'hFF, seg: 8'hFF});
      @(posedge clk);
      @(negedge clk);
      pop_check();
    end
    reset_i = 1'b0;
    k = 0;
    disp_s = 0; disp_m = 0; disp_h = 0;
    pend_s = 0; pend_m = 0; pend_h = 0;
    $display("reset held %0d cycles, checks=%0d", n, n_checks);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours_i   = 5'(h);
    minutes_i = 6'(m);
    seconds_i = 6'(s);
  endtask

  initial begin
    seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
    seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
    seg_tab[8] = 8'h80; seg_tab[9] = 8'h90;

    reset_i = 1'b1;
    set_time(12, 34, 56);

    // Reset state, then first frame shows 00-00-00.
    do_reset(3);
    run(FRAME);

    // Full frame 23:59:45 (after one frame still showing 12:34:56).
    set_time(23, 59, 45);
    run(2 * FRAME);

    // Snapshot coherence: inputs change while digit 3 is on.
    set_time(10, 20, 30);
    run(FRAME);
    run(14);
    set_time(11, 21, 31);
    run(FRAME - 14);
    run(FRAME);

    // Out-of-range fields.
    set_time(24, 5, 60);
    run(2 * FRAME);
    set_time(24, 5, 61);
    run(FRAME);

    // Separator with odd then even seconds.
    set_time(2, 1, 7);
    run(2 * FRAME);
    set_time(2, 1, 8);
    run(FRAME);

    // Conversion of every 6-bit value.
    for (int v = 0; v < 64; v++) begin
      set_time(v % 32, 63 - v, v);
      run(FRAME);
    end
    run(FRAME);

    // Reset while digit 5 is active.
    set_time(9, 8, 7);
    run(21);
    do_reset(1);
    run(FRAME);

    check("sb_empty", 8'(sb.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
